// File: rtl/simd_mem_pkg.sv
// Shared constants, beat derivation and FSM state type
// for the SIMD data memory.
package simd_mem_pkg;

  localparam int ELEM_W_DEF    = 16;
  localparam int LANES_DEF     = 16;
  localparam int ROW_LANES_DEF = 4;
  localparam int DEPTH_DEF     = 1024;

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    DONE
  } dmem_state_e;

  function automatic int dmem_beats(input int lanes, input int row_lanes);
    return lanes / row_lanes;
  endfunction

endpackage

// File: rtl/dmem_row_bank.sv
// Single-port row array with per-element write enables
// and a registered read port that holds between reads.
module dmem_row_bank #(
  parameter int ELEM_W    = 16,
  parameter int ROW_LANES = 4,
  parameter int ROWS      = 256,
  parameter int RAW       = $clog2(ROWS)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [RAW-1:0]              addr,
  input  logic                        re,
  input  logic [ROW_LANES-1:0]        we,
  input  logic [ROW_LANES*ELEM_W-1:0] wdata,
  output logic [ROW_LANES*ELEM_W-1:0] rdata
);

  logic [ROW_LANES*ELEM_W-1:0] mem [ROWS];

  always_ff @(posedge clk) begin
    for (int i = 0; i < ROW_LANES; i++) begin
      if (we[i]) begin
        mem[addr][i*ELEM_W +: ELEM_W] <= wdata[i*ELEM_W +: ELEM_W];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/simd_vec_dmem.sv
// SIMD data memory: scalar port plus beat-sequenced vector port.
// Optional per-lane store mask enabled by defining VMASK_EN.
module simd_vec_dmem
  import simd_mem_pkg::*;
#(
  parameter int ELEM_W    = ELEM_W_DEF,
  parameter int LANES     = LANES_DEF,
  parameter int ROW_LANES = ROW_LANES_DEF,
  parameter int DEPTH     = DEPTH_DEF,
  parameter int AW        = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    s_en,
  input  logic                    s_we,
  input  logic [AW-1:0]           s_addr,
  input  logic [ELEM_W-1:0]       s_wdata,
  output logic [ELEM_W-1:0]       s_rdata,
  output logic                    s_stall,
  input  logic                    v_req,
  output logic                    v_ready,
  input  logic                    v_we,
  input  logic [AW-1:0]           v_addr,
  input  logic [LANES*ELEM_W-1:0] v_wdata,
`ifdef VMASK_EN
  input  logic [LANES-1:0]        v_mask,
`endif
  output logic [LANES*ELEM_W-1:0] v_rdata,
  output logic                    v_busy,
  output logic                    v_done,
  output logic                    v_err
);

  localparam int BEATS = dmem_beats(LANES, ROW_LANES);
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int RLW   = $clog2(ROW_LANES);
  localparam int LW    = $clog2(LANES);
  localparam int ROWS  = DEPTH / ROW_LANES;
  localparam int RAW   = AW - RLW;
  localparam int ROW_W = ROW_LANES * ELEM_W;

  dmem_state_e state;
  logic [BW-1:0] beat;
  logic we_q;
  logic err_q;
  logic [RAW-1:0] base_q;
  logic [LANES*ELEM_W-1:0] wdata_q;
  logic [LANES-1:0] mask_q;

  logic s_pend;
  logic [RLW-1:0] s_lane;
  logic [ELEM_W-1:0] s_hold;

  logic accept, aligned, s_go, last;
  logic [RAW-1:0] b_addr;
  logic b_re;
  logic [ROW_LANES-1:0] b_we;
  logic [ROW_W-1:0] b_wdata;
  logic [ROW_W-1:0] b_rdata;
  logic [ELEM_W-1:0] s_elem;

  assign v_ready = (state == IDLE) & ~s_en;
  assign s_stall = s_en & (state != IDLE);
  assign s_go    = s_en & (state == IDLE);
  assign accept  = v_req & v_ready;
  assign aligned = (v_addr[LW-1:0] == '0);
  assign last    = (beat == BW'(BEATS - 1));
  assign v_busy  = (state != IDLE);
  assign v_done  = (state == DONE);
  assign v_err   = (state == DONE) & err_q;
  assign s_elem  = b_rdata[int'(s_lane)*ELEM_W +: ELEM_W];
  assign s_rdata = s_pend ? s_elem : s_hold;

  // Loads prefetch one row ahead so each beat lands its slice on time.
  always_comb begin
    b_addr  = '0;
    b_re    = 1'b0;
    b_we    = '0;
    b_wdata = '0;
    if (s_go) begin
      b_addr  = s_addr[AW-1:RLW];
      b_re    = ~s_we;
      b_we    = s_we ? (ROW_LANES'(1) << s_addr[RLW-1:0]) : '0;
      b_wdata = {ROW_LANES{s_wdata}};
    end else if (accept) begin
      b_addr = v_addr[AW-1:RLW];
      b_re   = ~v_we & aligned;
    end else if (state == XFER) begin
      if (we_q) begin
        b_addr  = base_q + RAW'(beat);
        b_we    = mask_q[int'(beat)*ROW_LANES +: ROW_LANES];
        b_wdata = wdata_q[int'(beat)*ROW_W +: ROW_W];
      end else begin
        b_addr = base_q + RAW'(beat) + RAW'(1);
        b_re   = ~last;
      end
    end
  end

  dmem_row_bank #(
    .ELEM_W   (ELEM_W),
    .ROW_LANES(ROW_LANES),
    .ROWS     (ROWS),
    .RAW      (RAW)
  ) u_bank (
    .clk  (clk),
    .reset(reset),
    .addr (b_addr),
    .re   (b_re),
    .we   (b_we),
    .wdata(b_wdata),
    .rdata(b_rdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      beat    <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      base_q  <= '0;
      wdata_q <= '0;
      mask_q  <= '0;
      v_rdata <= '0;
      s_pend  <= 1'b0;
      s_lane  <= '0;
      s_hold  <= '0;
    end else begin
      s_pend <= s_go & ~s_we;
      if (s_go & ~s_we) s_lane <= s_addr[RLW-1:0];
      if (s_pend) s_hold <= s_elem;
      unique case (state)
        IDLE: begin
          if (accept) begin
            we_q    <= v_we;
            base_q  <= v_addr[AW-1:RLW];
            wdata_q <= v_wdata;
`ifdef VMASK_EN
            mask_q  <= v_mask;
`else
            mask_q  <= '1;
`endif
            err_q   <= ~aligned;
            beat    <= '0;
            state   <= aligned ? XFER : DONE;
          end
        end
        XFER: begin
          if (!we_q) begin
            v_rdata[int'(beat)*ROW_W +: ROW_W] <= b_rdata;
          end
          if (last) begin
            beat  <= '0;
            state <= DONE;
          end else begin
            beat <= beat + BW'(1);
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_simd_vec_dmem.sv
// Scoreboard bench for simd_vec_dmem at default parameters.
module tb_simd_vec_dmem;

  logic clk = 0;
  logic reset;
  logic s_en, s_we;
  logic [9:0] s_addr;
  logic [15:0] s_wdata, s_rdata;
  logic s_stall, v_req, v_ready, v_we;
  logic [9:0] v_addr;
  logic [255:0] v_wdata, v_rdata;
  logic [15:0] v_mask;
  logic v_busy, v_done, v_err;

  int checks = 0;
  int errors = 0;
  logic [15:0] sq[$];
  logic [255:0] vq[$];

  always #5 clk = ~clk;

  simd_vec_dmem dut (
    .clk    (clk),
    .reset  (reset),
    .s_en   (s_en),
    .s_we   (s_we),
    .s_addr (s_addr),
    .s_wdata(s_wdata),
    .s_rdata(s_rdata),
    .s_stall(s_stall),
    .v_req  (v_req),
    .v_ready(v_ready),
    .v_we   (v_we),
    .v_addr (v_addr),
    .v_wdata(v_wdata),
`ifdef VMASK_EN
    .v_mask (v_mask),
`endif
    .v_rdata(v_rdata),
    .v_busy (v_busy),
    .v_done (v_done),
    .v_err  (v_err)
  );

  task automatic chk(input string tag, input logic [255:0] got,
                     input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] mkvec(input logic [15:0] base);
    logic [255:0] v;
    for (int i = 0; i < 16; i++) v[i*16 +: 16] = 16'(base + 16'(i));
    return v;
  endfunction

  task automatic s_write(input logic [9:0] a, input logic [15:0] d);
    @(negedge clk);
    s_en = 1; s_we = 1; s_addr = a; s_wdata = d;
    @(negedge clk);
    s_en = 0; s_we = 0;
  endtask

  task automatic s_read(input string tag, input logic [9:0] a,
                        input logic [15:0] exp);
    @(negedge clk);
    s_en = 1; s_we = 0; s_addr = a;
    sq.push_back(exp);
    @(negedge clk);
    s_en = 0;
    chk(tag, s_rdata, sq.pop_front());
  endtask

  task automatic vec_op(input string tag, input logic we,
                        input logic [9:0] a, input logic [255:0] d,
                        input logic [15:0] m, input logic [255:0] exp,
                        input int lat, input logic err);
    int n;
    int w;
    @(negedge clk);
    v_req = 1; v_we = we; v_addr = a; v_wdata = d; v_mask = m;
    if (!we) vq.push_back(exp);
    #1;
    w = 0;
    while (!v_ready && w < 20) begin
      @(negedge clk); #1; w++;
    end
    chk({tag, "_rdy"}, v_ready, 1);
    @(negedge clk);
    v_req = 0;
    n = 1;
    while (!v_done && n < 20) begin
      @(negedge clk); n++;
    end
    chk({tag, "_lat"}, n, lat);
    chk({tag, "_err"}, v_err, err);
    if (!we) chk({tag, "_data"}, v_rdata, vq.pop_front());
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] v32, vm;
    int n, pulses;
    reset = 1; s_en = 0; s_we = 0; s_addr = 0; s_wdata = 0;
    v_req = 0; v_we = 0; v_addr = 0; v_wdata = 0; v_mask = '1;
    repeat (2) @(negedge clk);
    reset = 0;
    #1;
    chk("rst_s_rdata", s_rdata, 0);
    chk("rst_v_rdata", v_rdata, 0);
    chk("rst_busy", v_busy, 0);
    chk("rst_done", v_done, 0);
    chk("rst_err", v_err, 0);
    chk("rst_stall", s_stall, 0);
    chk("rst_ready", v_ready, 1);

    s_write(5, 16'hBEEF);
    s_read("s_rd5", 5, 16'hBEEF);

    v32 = mkvec(16'h1000);
    vec_op("vst32", 1, 32, v32, '1, '0, 5, 0);
    for (int i = 0; i < 16; i++) s_read("s_rd_vec", 10'(32 + i), 16'(16'h1000 + i));
    vec_op("vld32", 0, 32, '0, '1, v32, 5, 0);
    chk("s_hold", s_rdata, 16'h100F);

    // scalar wins same-cycle conflict; vector follows next cycle
    @(negedge clk);
    s_en = 1; s_we = 0; s_addr = 5;
    v_req = 1; v_we = 0; v_addr = 32;
    #1;
    chk("conf_ready", v_ready, 0);
    chk("conf_stall", s_stall, 0);
    sq.push_back(16'hBEEF);
    @(negedge clk);
    s_en = 0;
    #1;
    chk("conf_s_rdata", s_rdata, sq.pop_front());
    chk("conf_ready2", v_ready, 1);
    vq.push_back(v32);
    @(negedge clk);
    v_req = 0;
    chk("conf_busy", v_busy, 1);
    s_en = 1; s_addr = 40;
    sq.push_back(16'h1008);
    #1;
    chk("xfer_stall", s_stall, 1);
    n = 1;
    while (!v_done && n < 20) begin
      @(negedge clk); n++;
    end
    #1;
    chk("conf_lat", n, 5);
    chk("done_stall", s_stall, 1);
    chk("conf_vdata", v_rdata, vq.pop_front());
    @(negedge clk);
    #1;
    chk("idle_stall", s_stall, 0);
    @(negedge clk);
    s_en = 0;
    chk("stall_rd", s_rdata, sq.pop_front());

    vec_op("vld33", 0, 33, '0, '1, v32, 1, 1);
    vec_op("vst33", 1, 33, {16{16'hDEAD}}, '1, '0, 1, 1);
    vec_op("vld32b", 0, 32, '0, '1, v32, 5, 0);

`ifdef VMASK_EN
    vm = v32;
    for (int i = 0; i < 8; i++) vm[i*16 +: 16] = 16'hFFFF;
    vec_op("vst_mask", 1, 32, {16{16'hFFFF}}, 16'h00FF, '0, 5, 0);
    vec_op("vld_mask", 0, 32, '0, 16'h0000, vm, 5, 0);
`else
    vm = v32;
`endif

    // reset at beat 2 of a store: rows 0 and 1 already written
    @(negedge clk);
    v_req = 1; v_we = 1; v_addr = 64; v_wdata = mkvec(16'hA000); v_mask = '1;
    @(negedge clk);
    v_req = 0;
    repeat (2) @(negedge clk);
    reset = 1;
    #1;
    chk("rst_mid_busy", v_busy, 0);
    chk("rst_mid_done", v_done, 0);
    chk("rst_mid_vrd", v_rdata, 0);
    @(negedge clk);
    reset = 0;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (v_done) pulses++;
    end
    chk("rst_mid_pulses", pulses, 0);
    s_read("rst_row0", 64, 16'hA000);
    s_read("rst_row1", 68, 16'hA004);
    vec_op("vld_after", 0, 32, '0, '1, vm, 5, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
